// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 32x32 multiplier among N_REQ requesters,
// with start/busy sequencing, product return and a sticky busy watchdog.
module mult_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [N_REQ-1:0]                         req,
  input  logic [32*N_REQ-1:0]                      req_a,
  input  logic [32*N_REQ-1:0]                      req_b,
  output logic [N_REQ-1:0]                         done,
  output logic [63:0]                              res_product,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] gnt_id,
  output logic                                     arb_busy,
  output logic                                     err,
  output logic                                     mult_start,
  output logic [31:0]                              mult_a,
  output logic [31:0]                              mult_b,
  input  logic                                     mult_busy,
  input  logic [63:0]                              mult_product
);

  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t            state, state_d;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [N_REQ-1:0]  done_d;
  logic [63:0]       res_d;
  logic [ID_W-1:0]   gnt_d;
  logic              arb_busy_d, err_d, start_d;
  logic [31:0]       a_d, b_d;

  logic [31:0]       a_arr [N_REQ];
  logic [31:0]       b_arr [N_REQ];
  logic              found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[32*g +: 32];
    assign b_arr[g] = req_b[32*g +: 32];
  end

  // First requesting index at or after rr_ptr, wrapping
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        pick_id = idx;
      end
    end
  end

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    cnt_d      = cnt;
    done_d     = '0;
    res_d      = res_product;
    gnt_d      = gnt_id;
    arb_busy_d = arb_busy;
    err_d      = err;
    start_d    = 1'b0;
    a_d        = mult_a;
    b_d        = mult_b;
    case (state)
      IDLE: begin
        if (found) begin
          a_d        = a_arr[pick_id];
          b_d        = b_arr[pick_id];
          gnt_d      = pick_id;
          arb_busy_d = 1'b1;
          start_d    = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (mult_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt == CNT_W'(1)) begin
          // Multiplier never acknowledged the start
          err_d   = 1'b1;
          res_d   = mult_product;
          done_d  = N_REQ'(1) << gnt_id;
          state_d = RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!mult_busy) begin
          res_d   = mult_product;
          done_d  = N_REQ'(1) << gnt_id;
          state_d = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          res_d   = mult_product;
          done_d  = N_REQ'(1) << gnt_id;
          state_d = RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        arb_busy_d = 1'b0;
        rr_ptr_d   = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      done        <= '0;
      res_product <= '0;
      gnt_id      <= '0;
      arb_busy    <= 1'b0;
      err         <= 1'b0;
      mult_start  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      cnt         <= cnt_d;
      done        <= done_d;
      res_product <= res_d;
      gnt_id      <= gnt_d;
      arb_busy    <= arb_busy_d;
      err         <= err_d;
      mult_start  <= start_d;
      mult_a      <= a_d;
      mult_b      <= b_d;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier whose
// busy length can be stretched or suppressed.
module tb_mult_share_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_a, req_b;
  logic [3:0]   done;
  logic [63:0]  res_product;
  logic [1:0]   gnt_id;
  logic         arb_busy, err, mult_start;
  logic [31:0]  mult_a, mult_b;
  logic         mult_busy;
  logic [63:0]  mult_product;

  int compared   = 0;
  int mismatched = 0;

  int mult_lat;
  bit ignore_start;
  int rem;

  mult_share_arbiter #(.N_REQ(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .done(done), .res_product(res_product), .gnt_id(gnt_id),
    .arb_busy(arb_busy), .err(err), .mult_start(mult_start),
    .mult_a(mult_a), .mult_b(mult_b), .mult_busy(mult_busy),
    .mult_product(mult_product)
  );

  always #5 clk = ~clk;

  // Multiplier model: busy for mult_lat cycles starting the cycle after start
  always @(posedge clk) begin
    if (reset) begin
      mult_busy    <= 1'b0;
      rem          <= 0;
      mult_product <= '0;
    end else if (mult_start && !ignore_start) begin
      mult_busy    <= 1'b1;
      rem          <= mult_lat;
      mult_product <= {32'b0, mult_a} * {32'b0, mult_b};
    end else if (rem > 1) begin
      rem <= rem - 1;
    end else begin
      rem       <= 0;
      mult_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count cycles from the drive point until a done pulse (bounded)
  task automatic wait_done(input int limit, output logic [3:0] d, output logic [63:0] p,
                           output int lat, output int starts, output bit err_at,
                           output bit err_early);
    d = '0; p = '0; lat = 0; starts = 0; err_at = 0; err_early = 0;
    while (lat < limit) begin
      @(posedge clk); #1;
      lat++;
      if (mult_start) starts++;
      if (|done) begin
        d = done; p = res_product; err_at = err;
        return;
      end
      if (err) err_early = 1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_done"}, 64'(done), 64'h0);
    check({tag, "_res"}, res_product, 64'h0);
    check({tag, "_gnt"}, 64'(gnt_id), 64'h0);
    check({tag, "_busy"}, 64'(arb_busy), 64'h0);
    check({tag, "_err"}, 64'(err), 64'h0);
    check({tag, "_start"}, 64'(mult_start), 64'h0);
    check({tag, "_a"}, 64'(mult_a), 64'h0);
    check({tag, "_b"}, 64'(mult_b), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed simulation still running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [3:0]  d;
    logic [63:0] p;
    int          lat, starts, done_cnt;
    bit          err_at, err_early;
    logic [63:0] exp_p [4];

    reset = 1'b1; req = '0; req_a = '0; req_b = '0;
    mult_lat = 2; ignore_start = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    reset = 1'b0;

    // Single request on 0: 3*5
    req = 4'b0001; req_a[31:0] = 32'd3; req_b[31:0] = 32'd5;
    wait_done(20, d, p, lat, starts, err_at, err_early);
    check("t1_lat", 64'(lat), 64'd5);
    check("t1_starts", 64'(starts), 64'd1);
    check("t1_done", 64'(d), 64'b0001);
    check("t1_prod", p, 64'h0000_0000_0000_000F);
    check("t1_gnt", 64'(gnt_id), 64'd0);
    check("t1_rbusy", 64'(arb_busy), 64'd1);
    req = '0;
    @(posedge clk); #1;
    check("t1_idle_busy", 64'(arb_busy), 64'd0);
    check("t1_idle_done", 64'(done), 64'd0);

    // Requester 2, max operands
    req = 4'b0100; req_a[95:64] = 32'hFFFF_FFFF; req_b[95:64] = 32'hFFFF_FFFF;
    wait_done(20, d, p, lat, starts, err_at, err_early);
    check("t2_done", 64'(d), 64'b0100);
    check("t2_prod", p, 64'hFFFF_FFFE_0000_0001);
    check("t2_err", 64'(err_at), 64'd0);
    check("t2_gnt", 64'(gnt_id), 64'd2);
    req = '0;
    @(posedge clk); #1;

    // All four requesting from reset: grants 0,1,2,3,0
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_a = {32'hFFFF_FFFF, 32'd12345, 32'h0001_0000, 32'd7};
    req_b = {32'd2,         32'd100,   32'h0001_0000, 32'd9};
    exp_p[0] = 64'h0000_0000_0000_003F;
    exp_p[1] = 64'h0000_0001_0000_0000;
    exp_p[2] = 64'h0000_0000_0012_D644;
    exp_p[3] = 64'h0000_0001_FFFF_FFFE;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(20, d, p, lat, starts, err_at, err_early);
      check($sformatf("t3_done%0d", k), 64'(d), 64'(4'b0001 << (k % 4)));
      check($sformatf("t3_prod%0d", k), p, exp_p[k % 4]);
      check($sformatf("t3_gnt%0d", k), 64'(gnt_id), 64'(k % 4));
    end
    req = '0;
    @(posedge clk); #1;

    // Requester 1 drops req one cycle after its grant
    req = 4'b0010; req_a[63:32] = 32'd6; req_b[63:32] = 32'd7;
    @(posedge clk); #1;
    check("t4_granted", 64'(arb_busy), 64'd1);
    check("t4_gnt", 64'(gnt_id), 64'd1);
    check("t4_op_a", 64'(mult_a), 64'd6);
    req = '0;
    req_a[63:32] = 32'd0;
    wait_done(20, d, p, lat, starts, err_at, err_early);
    check("t4_lat", 64'(lat), 64'd4);
    check("t4_done", 64'(d), 64'b0010);
    check("t4_prod", p, 64'h2A);
    @(posedge clk); #1;

    // Multiplier busy stuck for 70 cycles: watchdog fires after 64
    mult_lat = 70;
    req = 4'b1000; req_a[127:96] = 32'd5; req_b[127:96] = 32'd5;
    wait_done(100, d, p, lat, starts, err_at, err_early);
    check("t5_lat", 64'(lat), 64'd67);
    check("t5_done", 64'(d), 64'b1000);
    check("t5_err", 64'(err_at), 64'd1);
    check("t5_err_early", 64'(err_early), 64'd0);
    check("t5_prod", p, 64'h19);
    req = '0; mult_lat = 2;
    @(posedge clk); #1;
    req = 4'b0001; req_a[31:0] = 32'd2; req_b[31:0] = 32'd3;
    wait_done(20, d, p, lat, starts, err_at, err_early);
    check("t5b_done", 64'(d), 64'b0001);
    check("t5b_prod", p, 64'h6);
    check("t5b_err_sticky", 64'(err_at), 64'd1);
    req = '0;
    @(posedge clk); #1;

    // Reset during WAIT_DONE aborts the operation
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals("rst1");
    mult_lat = 10;
    req = 4'b0100; req_a[95:64] = 32'd9; req_b[95:64] = 32'd9;
    repeat (4) @(posedge clk);
    #1;
    check("t6_inflight", 64'(arb_busy), 64'd1);
    reset = 1'b1; req = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals("t6_abort");
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (|done) done_cnt++;
    end
    check("t6_no_done", 64'(done_cnt), 64'd0);

    // Multiplier ignores start: err after two idle WAIT_BUSY cycles
    mult_lat = 2; ignore_start = 1;
    req = 4'b0001; req_a[31:0] = 32'd1; req_b[31:0] = 32'd1;
    wait_done(20, d, p, lat, starts, err_at, err_early);
    check("t7_lat", 64'(lat), 64'd4);
    check("t7_done", 64'(d), 64'b0001);
    check("t7_err", 64'(err_at), 64'd1);
    req = '0; ignore_start = 0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one mult32x32_fast instance among N_REQ requesters using round-robin arbitration.
- Each granted request is handled in four steps:
  - latch the requester's operands;
  - sequence the multiplier's start/busy handshake;
  - capture the 64-bit product;
  - return it with a one-cycle done pulse to the owning requester.
- Sits between the calculator's operation units and the shared multiplier.
- Includes a watchdog that flags a multiplier that never completes.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles mult_busy may stay high before err is raised.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req  input  N_REQ  per-requester request level
- req_a  input  32*N_REQ  operand a; requester i uses bits [32i+31:32i]
- req_b  input  32*N_REQ  operand b, same packing as req_a
- done  output  N_REQ  one-hot, one-cycle completion pulse
- res_product  output  64  result; valid when any done bit is high, held until the next capture
- gnt_id  output  $clog2(N_REQ)  index of the current/last granted requester
- arb_busy  output  1  high from grant until the done cycle, inclusive
- err  output  1  sticky timeout flag; cleared only by reset
- mult_start  output  1  start pulse to the multiplier
- mult_a  output  32  latched operand a
- mult_b  output  32  latched operand b
- mult_busy  input  1  multiplier busy
- mult_product  input  64  multiplier product

Behaviour:
- Clocking and reset
  - Single clock domain.
  - Synchronous active-high reset, which has priority over every other event. Reset mid-operation aborts it: no done pulse, operands discarded.
  - Reset values:
    - state=IDLE.
    - done=0, mult_start=0, arb_busy=0, err=0.
    - res_product=0, mult_a=0, mult_b=0, gnt_id=0.
    - rr_ptr=0, toggling to point at requester 0 first.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE
  - If any req bit is high, pick the first requester set at or after rr_ptr, wrapping modulo N_REQ.
  - Latch its req_a/req_b into mult_a/mult_b.
  - Set gnt_id, set arb_busy, and go to START.
  - No req: stay in IDLE.
- START
  - mult_start=1 for exactly this cycle; mult_a/mult_b are already stable.
  - Go to WAIT_BUSY.
- WAIT_BUSY
  - If mult_busy=1, go to WAIT_DONE.
  - If mult_busy is still 0 after 2 cycles in this state (start missed), set err and go to RESP using the current mult_product.
- WAIT_DONE
  - A per-operation cycle counter increments while mult_busy=1.
  - When mult_busy=0: capture mult_product into res_product and go to RESP.
  - If the counter reaches TIMEOUT: set err, capture mult_product anyway and go to RESP.
- RESP
  - done[gnt_id]=1 for this cycle only and arb_busy=1.
  - rr_ptr becomes (gnt_id+1) mod N_REQ.
  - Go to IDLE; arb_busy=0 from the next cycle.
- Latency
  - Grant decision at cycle t; mult_start at t+1.
  - If the multiplier holds busy for cycles t+2..t+K+1, done occurs at t+K+3.
  - Minimum turnaround between back-to-back grants: one IDLE cycle after RESP.
- Operand hold
  - mult_a/mult_b change only on a grant.
  - Requesters may change req_a/req_b after the grant cycle.
- Requester rules
  - A requester keeps req high until it sees its done bit.
  - If req drops mid-operation, the operation still completes and done still pulses.
  - If req is still high the cycle after done, it is treated as a new request and arbitrated fairly (rr_ptr has already advanced past it).
- Simultaneous requests: strictly round-robin; no requester waits more than N_REQ-1 operations.
- Outputs: all are registered. The done bits are mutually exclusive and are never high outside RESP.

Test Plan:
- Single request, req[0] with a=3, b=5 -> mult_start pulses once; done[0] at t+K+3; res_product=0x000000000000000F; gnt_id=0.
- req[2] with a=0xFFFFFFFF, b=0xFFFFFFFF -> res_product=0xFFFFFFFE00000001; done=4'b0100; err=0.
- All four req high from reset, each with distinct operands -> grants in order 0,1,2,3,0; each done matches the product of its own operands.
- req[1] drops one cycle after its grant -> operation finishes and done[1] still pulses.
- Forced mult_busy stuck at 1 for 70 cycles, TIMEOUT=64 -> err=1 after 64 busy cycles; done pulses; next request is accepted; err stays 1.
- Reset asserted during WAIT_DONE -> next cycle state=IDLE and all outputs at reset values; no done pulse for the aborted request.
